// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared types and constants for the VGA timing receiver:
//                receiver state encoding, default counter widths and the
//                nominal source timing the receiver is built around.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Default widths of the line/frame counters and the Hsync width counter
  localparam int c_CNT_W_DEF = 11;
  localparam int c_HSW_W_DEF = 8;

  // Nominal source timing (clocks per line, lines per frame, Hsync width)
  localparam int c_NOM_LINE_CLKS   = 768;
  localparam int c_NOM_FRAME_LINES = 1024;
  localparam int c_NOM_HSYNC_CLKS  = 16;

  // Lock-acquisition state machine
  typedef enum logic [2:0] {
    SEARCH = 3'd0,
    HMEAS  = 3'd1,
    VWAIT  = 3'd2,
    FMEAS  = 3'd3,
    LOCKED = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge
//  Description : Registers an active-low sync input once, keeps the previous
//                registered value and decodes falling / rising edges.
//                Both registers reset to 1 (sync idle) so that releasing
//                reset never produces a spurious edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  logic sig_q;
  logic prev_q;

  // Input sample register plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sig_q  <= sig_i;
      prev_q <= sig_q;
    end
  end

  assign level_o = sig_q;
  assign fall_o  = prev_q & ~sig_q;
  assign rise_o  = ~prev_q & sig_q;

endmodule
`default_nettype wire

// File: rtl/vga_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_rx
//  Description : Recovers VGA timing from active-low Hsync/Vsync. Measures
//                line length, frame height and Hsync width, locks once two
//                consistent measurements agree and reports the beam position
//                together with line/frame strobes, mismatch errors and a
//                missing-Hsync timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int CNT_W = c_CNT_W_DEF,
  parameter int HSW_W = c_HSW_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Hsync,
  input  logic             Vsync,
  output logic             locked,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic [HSW_W-1:0] hs_width,
  output logic             line_strobe,
  output logic             frame_strobe,
  output logic             line_err,
  output logic             frame_err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] c_HCNT_MAX = '1;
  localparam logic [HSW_W-1:0] c_HSW_MAX  = '1;

  logic w_hs_lvl, w_hs_fall, w_hs_rise;
  logic w_vs_lvl_unused, w_vs_fall, w_vs_rise_unused;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, vcnt_q;
  logic [HSW_W-1:0] hsw_cnt_q, hs_width_q;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
  logic             line_stb_q, line_stb_d;
  logic             frame_stb_q, frame_stb_d;
  logic             line_err_q, line_err_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0] w_line_meas, w_frame_meas;
  logic             w_line_bad, w_frame_bad, w_hcnt_max;

  sync_edge u_hs_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (Hsync),
    .level_o (w_hs_lvl),
    .fall_o  (w_hs_fall),
    .rise_o  (w_hs_rise)
  );

  sync_edge u_vs_edge (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (Vsync),
    .level_o (w_vs_lvl_unused),
    .fall_o  (w_vs_fall),
    .rise_o  (w_vs_rise_unused)
  );

  // Count includes the clock of the edge itself, hence the +1
  assign w_line_meas  = hcnt_q + CNT_W'(1);
  assign w_frame_meas = vcnt_q + CNT_W'(1);
  assign w_line_bad   = w_hs_fall & (w_line_meas != line_len_q);
  assign w_frame_bad  = w_vs_fall & (w_frame_meas != frame_lines_q);
  assign w_hcnt_max   = (hcnt_q == c_HCNT_MAX);

  // Horizontal counter restarts each line and parks at its maximum
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
    end else if (w_hs_fall) begin
      hcnt_q <= '0;
    end else if (!w_hcnt_max) begin
      hcnt_q <= hcnt_q + CNT_W'(1);
    end
  end

  // Vertical counter: frame start wins over a coincident line start
  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt_q <= '0;
    end else if (w_vs_fall) begin
      vcnt_q <= '0;
    end else if (w_hs_fall) begin
      vcnt_q <= vcnt_q + CNT_W'(1);
    end
  end

  // Saturating Hsync-low width counter, latched when Hsync returns high
  always_ff @(posedge clk) begin
    if (rst) begin
      hsw_cnt_q  <= '0;
      hs_width_q <= '0;
    end else begin
      if (!w_hs_lvl) begin
        if (hsw_cnt_q != c_HSW_MAX) hsw_cnt_q <= hsw_cnt_q + HSW_W'(1);
      end else begin
        hsw_cnt_q <= '0;
      end
      if (w_hs_rise) hs_width_q <= hsw_cnt_q;
    end
  end

  // State, measurement and event-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      line_stb_q    <= 1'b0;
      frame_stb_q   <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      line_stb_q    <= line_stb_d;
      frame_stb_q   <= frame_stb_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      timeout_q     <= timeout_d;
    end
  end

  // Lock acquisition: measure a line, confirm it across a frame, then track
  always_comb begin
    state_d       = state_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    line_stb_d    = 1'b0;
    frame_stb_d   = 1'b0;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;
    timeout_d     = 1'b0;

    case (state_q)
      SEARCH: begin
        if (w_hs_fall) state_d = HMEAS;
      end
      HMEAS: begin
        if (w_hs_fall) begin
          line_len_d = w_line_meas;
          state_d    = VWAIT;
        end
      end
      VWAIT: begin
        if (w_line_bad) begin
          line_err_d = 1'b1;
          state_d    = HMEAS;
        end else if (w_vs_fall) begin
          state_d = FMEAS;
        end
      end
      FMEAS: begin
        if (w_line_bad) begin
          line_err_d = 1'b1;
          state_d    = HMEAS;
        end else if (w_vs_fall) begin
          frame_lines_d = w_frame_meas;
          state_d       = LOCKED;
        end
      end
      LOCKED: begin
        // Both checks report; either one drops lock
        line_err_d  = w_line_bad;
        frame_err_d = w_frame_bad;
        if (w_line_bad || w_frame_bad) begin
          state_d = HMEAS;
        end else begin
          line_stb_d  = w_hs_fall;
          frame_stb_d = w_vs_fall;
        end
      end
      default: state_d = SEARCH;
    endcase

    // Missing Hsync overrides everything else; measurements are kept
    if ((state_q != SEARCH) && w_hcnt_max && !w_hs_fall) begin
      state_d       = SEARCH;
      timeout_d     = 1'b1;
      frame_lines_d = frame_lines_q;
      line_stb_d    = 1'b0;
      frame_stb_d   = 1'b0;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign pixel_x      = locked ? hcnt_q : '0;
  assign pixel_y      = locked ? vcnt_q : '0;
  assign line_len     = line_len_q;
  assign frame_lines  = frame_lines_q;
  assign hs_width     = hs_width_q;
  assign line_strobe  = line_stb_q;
  assign frame_strobe = frame_stb_q;
  assign line_err     = line_err_q;
  assign frame_err    = frame_err_q;
  assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_rx
//  Description : Self-checking bench for vga_sync_rx. Drives a scaled VGA
//                source (random line/frame geometry and Hsync widths) and
//                compares against a line-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_rx;

  localparam int CNT_W = 11;
  localparam int HSW_W = 8;
  localparam int TMO_I = (1 << CNT_W) + 1;  // line cycle at which timeout shows
  localparam int HSW_SAT = (1 << HSW_W) - 1;

  logic             clk = 1'b0;
  logic             rst, Hsync, Vsync;
  logic             locked;
  logic [CNT_W-1:0] pixel_x, pixel_y, line_len, frame_lines;
  logic [HSW_W-1:0] hs_width;
  logic             line_strobe, frame_strobe, line_err, frame_err, timeout;

  int total = 0;
  int bad   = 0;

  // Reference model: lock progress, learnt geometry, lines since frame start
  int m_stage, m_len, m_frame, m_lines, m_hsw, prev_len;
  int nl, fl;

  always #5 clk = ~clk;

  vga_sync_rx #(.CNT_W(CNT_W), .HSW_W(HSW_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .Hsync        (Hsync),
    .Vsync        (Vsync),
    .locked       (locked),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .line_len     (line_len),
    .frame_lines  (frame_lines),
    .hs_width     (hs_width),
    .line_strobe  (line_strobe),
    .frame_strobe (frame_strobe),
    .line_err     (line_err),
    .frame_err    (frame_err),
    .timeout      (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_stage = 0; m_len = 0; m_frame = 0; m_lines = 1; m_hsw = 0;
  endfunction

  // One line start: returns {line_strobe, frame_strobe, line_err, frame_err, timeout}
  function automatic logic [4:0] model_line_start(input bit vs);
    bit lbad, ls, fs, le, fe;
    int fmeas;
    ls = 0; fs = 0; le = 0; fe = 0;
    lbad  = (prev_len != m_len);
    fmeas = m_lines;
    m_lines = vs ? 1 : m_lines + 1;
    case (m_stage)
      0: m_stage = 1;
      1: begin m_len = prev_len; m_stage = 2; end
      2: if (lbad) begin le = 1; m_stage = 1; end else if (vs) m_stage = 3;
      3: if (lbad) begin le = 1; m_stage = 1; end
         else if (vs) begin m_frame = fmeas; m_stage = 4; end
      default: begin
        le = lbad;
        fe = vs && (fmeas != m_frame);
        if (le || fe) m_stage = 1;
        else begin ls = 1; fs = vs; end
      end
    endcase
    return {ls, fs, le, fe, 1'b0};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_events"}, {locked, line_strobe, frame_strobe, line_err, frame_err, timeout}, 0);
    check({tag, "_line_len"}, line_len, 0);
    check({tag, "_frame_lines"}, frame_lines, 0);
    check({tag, "_hs_width"}, hs_width, 0);
    check({tag, "_pixel_x"}, pixel_x, 0);
    check({tag, "_pixel_y"}, pixel_y, 0);
  endtask

  // One source line: Hsync low for hsw clocks, Vsync low for the whole line if vs
  task automatic send_line(input int len, input int hsw, input bit vs, input int rst_at);
    logic [4:0] ev;
    bit lk;
    for (int i = 0; i < len; i++) begin
      Hsync = (i >= hsw);
      Vsync = !vs;
      rst   = (i == rst_at);
      tick();
      if (i == rst_at) begin
        model_reset();
        check_idle("mid_reset");
      end else begin
        ev = '0;
        if (i == 1) ev = model_line_start(vs);
        if (i == TMO_I && m_stage != 0) begin
          ev[0] = 1'b1;
          m_stage = 0;
        end
        if (i == hsw + 1) m_hsw = (hsw > HSW_SAT) ? HSW_SAT : hsw;
        lk = (m_stage == 4);
        check("events", {locked, line_strobe, frame_strobe, line_err, frame_err, timeout},
              {lk, ev});
        if (i == 1 || i == len / 2) begin
          check("pixel_x", pixel_x, lk ? i - 1 : 0);
          check("pixel_y", pixel_y, lk ? m_lines - 1 : 0);
        end
      end
    end
    rst = 1'b0;
    prev_len = len;
    check("hs_width", hs_width, m_hsw);
    check("line_len", line_len, m_len);
    check("frame_lines", frame_lines, m_frame);
  endtask

  // A frame (or its tail from line 'first'); one line may be altered
  task automatic send_frame(input int lines, input int first, input int odd_line,
                            input int odd_len, input int odd_hsw, input int rst_line);
    int len, hsw;
    for (int l = first; l < lines; l++) begin
      len = (l == odd_line) ? odd_len : nl;
      hsw = (l == odd_line && odd_hsw > 0) ? odd_hsw : int'($urandom_range(2, 10));
      send_line(len, hsw, (l == 0), (l == rst_line) ? nl / 2 + 2 : -1);
    end
  endtask

  initial begin
    rst = 1'b1; Hsync = 1'b1; Vsync = 1'b1;
    model_reset();
    prev_len = 0;
    nl = int'($urandom_range(40, 70));
    fl = int'($urandom_range(8, 14));

    tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    tick(); tick();
    check_idle("idle");

    // Acquire: start mid-frame, lock expected at the second frame start
    send_frame(fl, 1, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    check("not_locked_before_2nd_vs", locked, 0);
    send_frame(fl, 0, -1, 0, 0, -1);
    check("locked_after_acquire", locked, 1);
    check("acq_line_len", line_len, nl);
    check("acq_frame_lines", frame_lines, fl);

    // Short line while locked, then recovery
    send_frame(fl, 0, 5, nl - 7, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    check("relock_after_line_err", locked, 1);

    // Frame one line short, then recovery
    send_frame(fl - 1, 0, -1, 0, 0, -1);
    check("line_len_kept_frame_err", line_len, nl);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    check("relock_after_frame_err", locked, 1);

    // Missing Hsync long enough to time out
    send_frame(fl, 0, 3, 2100, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    check("relock_after_timeout", locked, 1);

    // Single-cycle reset in the middle of a line
    send_frame(fl, 0, -1, 0, 0, 4);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    check("relock_after_reset", locked, 1);
    check("reset_line_len", line_len, nl);

    // Over-long Hsync pulse saturates the width measurement
    send_frame(fl, 0, 3, 400, 300, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    send_frame(fl, 0, -1, 0, 0, -1);
    check("relock_after_sat", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
